mac_acc: RTL and testbench



---
 rtl/mac_acc_pkg.sv | 12 +
 rtl/mac_acc_out_buf.sv | 50 +++++
 rtl/mac_acc.sv | 128 ++++++++++++
 tb/tb_mac_acc.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mac_acc_pkg.sv
// Shared types and default widths for the windowed multiply-accumulate stage.
package mac_acc_pkg;

    localparam int MAC_WIDTH_IN  = 8;
    localparam int MAC_WIDTH_ACC = 24;

    typedef enum logic [0:0] {
        ACCUM      = 1'b0,
        FLUSH_WAIT = 1'b1
    } mac_state_e;

endpackage : mac_acc_pkg

// File: rtl/mac_acc_out_buf.sv
// Single-entry valid/ready result register. A load on the same edge as a pop
// wins, so the slot stays full with the new value.
module mac_out_buf #(
    parameter int WIDTH = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             free_o
);

    logic             valid_q;
    logic             valid_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Next-state for the slot: refill beats pop, pop empties, otherwise hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= {WIDTH{1'b0}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign free_o  = ~valid_q | ready_i;

endmodule : mac_out_buf

// File: rtl/mac_acc.sv
// Windowed signed multiply-accumulate. Products are registered, folded into
// the accumulator, and the window sum is flushed on each rising edge of the
// external window counter's ready level.
module mac_acc
    import mac_acc_pkg::*;
#(
    parameter int WIDTH_IN  = MAC_WIDTH_IN,
    parameter int WIDTH_ACC = MAC_WIDTH_ACC
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic signed [WIDTH_IN-1:0]  a_i,
    input  logic signed [WIDTH_IN-1:0]  b_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    output logic                        cnt_en_o,
    input  logic                        window_done_i,
    output logic signed [WIDTH_ACC-1:0] out_data_o,
    output logic                        out_valid_o,
    input  logic                        out_ready_i
);

    mac_state_e                  state_q;
    mac_state_e                  state_d;
    logic signed [WIDTH_ACC-1:0] prod_q;
    logic signed [WIDTH_ACC-1:0] prod_d;
    logic                        prod_v_q;
    logic                        prod_v_d;
    logic signed [WIDTH_ACC-1:0] acc_q;
    logic signed [WIDTH_ACC-1:0] acc_d;
    logic                        done_q;
    logic                        done_d;

    logic signed [2*WIDTH_IN-1:0] mult_s;
    logic signed [WIDTH_ACC-1:0]  prod_ext_s;
    logic signed [WIDTH_ACC-1:0]  sum_s;
    logic                         accept_s;
    logic                         rise_s;
    logic                         free_s;
    logic                         load_s;
    logic [WIDTH_ACC-1:0]         load_data_s;

    assign mult_s     = a_i * b_i;
    assign prod_ext_s = WIDTH_ACC'(mult_s);
    assign sum_s      = acc_q + (prod_v_q ? prod_q : {WIDTH_ACC{1'b0}});
    assign in_ready_o = (state_q == ACCUM);
    assign accept_s   = in_valid_i & in_ready_o;
    assign cnt_en_o   = accept_s;
    // done_q powers up high so a level already present is not seen as a rise
    assign rise_s     = window_done_i & ~done_q;
    assign done_d     = window_done_i;

    // Product stage, accumulator and flush decisions.
    always_comb begin
        state_d     = state_q;
        prod_d      = prod_q;
        prod_v_d    = prod_v_q;
        acc_d       = acc_q;
        load_s      = 1'b0;
        load_data_s = sum_s;
        case (state_q)
            ACCUM: begin
                if (accept_s) begin
                    prod_d   = prod_ext_s;
                    prod_v_d = 1'b1;
                end else begin
                    prod_v_d = 1'b0;
                end
                if (rise_s && free_s) begin
                    load_s      = 1'b1;
                    load_data_s = sum_s;
                    acc_d       = {WIDTH_ACC{1'b0}};
                end else if (rise_s) begin
                    // Slot busy: close the window in acc and wait; a pair
                    // accepted now stays parked in prod for the next window.
                    acc_d   = sum_s;
                    state_d = FLUSH_WAIT;
                end else begin
                    acc_d = sum_s;
                end
            end
            FLUSH_WAIT: begin
                if (free_s) begin
                    load_s      = 1'b1;
                    load_data_s = acc_q;
                    acc_d       = {WIDTH_ACC{1'b0}};
                    state_d     = ACCUM;
                end else begin
                    state_d = FLUSH_WAIT;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // State, product, accumulator and edge-detect registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ACCUM;
            prod_q   <= {WIDTH_ACC{1'b0}};
            prod_v_q <= 1'b0;
            acc_q    <= {WIDTH_ACC{1'b0}};
            done_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            prod_q   <= prod_d;
            prod_v_q <= prod_v_d;
            acc_q    <= acc_d;
            done_q   <= done_d;
        end
    end

    mac_out_buf #(
        .WIDTH (WIDTH_ACC)
    ) u_out_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (load_s),
        .data_i  (load_data_s),
        .ready_i (out_ready_i),
        .valid_o (out_valid_o),
        .data_o  (out_data_o),
        .free_o  (free_s)
    );

endmodule : mac_acc

// File: tb/tb_mac_acc.sv
// Bench for mac_acc: a behavioural 4-pair window counter, a window-sum
// reference model, a vector table and hand-written corner sequences.
module tb_mac_acc;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic signed [7:0]  a_i = 8'sd0;
    logic signed [7:0]  b_i = 8'sd0;
    logic               in_valid_i = 1'b0;
    logic               out_ready_i = 1'b0;
    logic               window_done_i = 1'b0;
    logic               in_ready_o, cnt_en_o, out_valid_o;
    logic signed [23:0] out_data_o;
    logic               in_ready16, cnt_en16, out_valid16;
    logic signed [15:0] out_data16;

    int checks = 0;
    int errors = 0;

    // reference model state
    bit                 m_full, m_fw, m_done_prev, lvl, force_done;
    logic signed [23:0] m_sum, m_closed, m_out;
    int                 cnt, hold, en_count, valid_count;

    typedef struct packed {
        logic [3:0][7:0]    a;
        logic [7:0]         b;
        logic signed [23:0] exp;
        logic signed [15:0] exp16;
    } win_t;
    win_t tbl [5];

    always #5 clk = ~clk;

    mac_acc #(.WIDTH_IN(8), .WIDTH_ACC(24)) dut (
        .clk(clk), .rst_n(rst_n), .a_i(a_i), .b_i(b_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .cnt_en_o(cnt_en_o),
        .window_done_i(window_done_i), .out_data_o(out_data_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i)
    );

    mac_acc #(.WIDTH_IN(8), .WIDTH_ACC(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .a_i(a_i), .b_i(b_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready16), .cnt_en_o(cnt_en16),
        .window_done_i(window_done_i), .out_data_o(out_data16),
        .out_valid_o(out_valid16), .out_ready_i(out_ready_i)
    );

    task automatic chk(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_full = 1'b0; m_fw = 1'b0; m_done_prev = 1'b1; lvl = 1'b0;
        m_sum = 24'sd0; m_closed = 24'sd0; m_out = 24'sd0;
        cnt = 0; hold = 0;
    endtask

    // One clock cycle: drive at negedge, advance the model at posedge, compare.
    task automatic step(input logic signed [7:0] av, input logic signed [7:0] bv,
                        input bit v, input bit r);
        int pa, pb;
        bit acc_ok, rise, free;
        @(negedge clk);
        a_i = av; b_i = bv; in_valid_i = v; out_ready_i = r;
        window_done_i = lvl | force_done;
        #1;
        chk("cnt_en", cnt_en_o, v & ~m_fw);
        if (cnt_en_o) en_count++;
        @(posedge clk);
        pa = av; pb = bv;
        acc_ok = v && !m_fw;
        rise = window_done_i && !m_done_prev;
        free = !m_full || r;
        if (m_full && r) m_full = 1'b0;
        if (!m_fw) begin
            if (rise) begin
                if (free) begin m_out = m_sum; m_full = 1'b1; end
                else begin m_closed = m_sum; m_fw = 1'b1; end
                m_sum = 24'sd0;
            end
            if (acc_ok) m_sum = m_sum + 24'(pa * pb);
        end else if (free) begin
            m_out = m_closed; m_full = 1'b1; m_fw = 1'b0;
        end
        m_done_prev = window_done_i;
        if (lvl) begin
            hold--;
            if (hold == 0) lvl = 1'b0;
        end
        if (acc_ok) begin
            cnt++;
            if (cnt == 4) begin cnt = 0; lvl = 1'b1; hold = 3; end
        end
        #1;
        chk("out_valid", out_valid_o, m_full);
        if (m_full) chk("out_data", out_data_o, m_out);
        chk("in_ready", in_ready_o, !m_fw);
        if (out_valid_o) valid_count++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
        model_reset();
        window_done_i = force_done;
        #1;
        chk("rst_out_valid", out_valid_o, 1'b0);
        chk("rst_out_data", out_data_o, 24'sd0);
        chk("rst_in_ready", in_ready_o, 1'b1);
        chk("rst_cnt_en", cnt_en_o, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        force_done = 1'b0; en_count = 0; valid_count = 0;
        tbl[0].a = {8'd4, 8'd3, 8'd2, 8'd1};             tbl[0].b = 8'd2;
        tbl[0].exp = 24'sd20;      tbl[0].exp16 = 16'sd20;
        tbl[1].a = {8'h80, 8'h80, 8'h80, 8'h80};         tbl[1].b = 8'd127;
        tbl[1].exp = -24'sd65024;  tbl[1].exp16 = 16'sd512;
        tbl[2].a = {8'd0, 8'd0, 8'd0, 8'd0};             tbl[2].b = 8'd0;
        tbl[2].exp = 24'sd0;       tbl[2].exp16 = 16'sd0;
        tbl[3].a = {8'd127, 8'd127, 8'd127, 8'd127};     tbl[3].b = 8'd127;
        tbl[3].exp = 24'sd64516;   tbl[3].exp16 = -16'sd1020;
        tbl[4].a = {8'h02, 8'hFF, 8'h07, 8'hFD};         tbl[4].b = 8'hFB;
        tbl[4].exp = -24'sd25;     tbl[4].exp16 = -16'sd25;

        do_reset();

        // table: back-to-back windows, result one edge after the 4th accept
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 4; k++) step(tbl[i].a[k], tbl[i].b, 1'b1, 1'b1);
            step(8'sd0, 8'sd0, 1'b0, 1'b1);
            chk("tbl_valid", out_valid_o, 1'b1);
            chk("tbl_data", out_data_o, tbl[i].exp);
            chk("tbl_data16", out_data16, tbl[i].exp16);
            step(8'sd0, 8'sd0, 1'b0, 1'b1);
            chk("tbl_one_cycle", out_valid_o, 1'b0);
            step(8'sd0, 8'sd0, 1'b0, 1'b1);
        end

        // backpressure: first result held, second window waits in FLUSH_WAIT
        for (int k = 0; k < 4; k++) step(8'sd1, 8'sd1, 1'b1, 1'b0);
        step(8'sd1, 8'sd1, 1'b1, 1'b0);
        chk("bp_first", out_data_o, 24'sd4);
        for (int k = 0; k < 3; k++) step(8'sd1, 8'sd1, 1'b1, 1'b0);
        chk("bp_held", out_data_o, 24'sd4);
        step(8'sd1, 8'sd1, 1'b1, 1'b0);
        chk("bp_fw_ready", in_ready_o, 1'b0);
        step(8'sd1, 8'sd1, 1'b1, 1'b0);
        step(8'sd1, 8'sd1, 1'b1, 1'b0);
        chk("bp_fw_stall", in_ready_o, 1'b0);
        step(8'sd0, 8'sd0, 1'b0, 1'b1);
        chk("bp_second_valid", out_valid_o, 1'b1);
        chk("bp_second", out_data_o, 24'sd4);
        chk("bp_resume", in_ready_o, 1'b1);
        for (int k = 0; k < 3; k++) step(8'sd1, 8'sd1, 1'b1, 1'b1);
        step(8'sd0, 8'sd0, 1'b0, 1'b1);
        chk("bp_third", out_data_o, 24'sd4);
        for (int k = 0; k < 3; k++) step(8'sd0, 8'sd0, 1'b0, 1'b1);

        // bubbles: valid on every third cycle
        en_count = 0;
        for (int k = 0; k < 10; k++) step(8'sd5, 8'sd1, (k % 3) == 0, 1'b1);
        step(8'sd0, 8'sd0, 1'b0, 1'b1);
        chk("bub_data", out_data_o, 24'sd20);
        chk("bub_cnt_en", en_count, 4);
        for (int k = 0; k < 3; k++) step(8'sd0, 8'sd0, 1'b0, 1'b1);

        // level held high: exactly one (empty) flush
        valid_count = 0;
        force_done = 1'b1;
        for (int k = 0; k < 6; k++) step(8'sd0, 8'sd0, 1'b0, 1'b1);
        chk("held_one_flush", valid_count, 1);
        force_done = 1'b0;
        step(8'sd0, 8'sd0, 1'b0, 1'b1);

        // reset mid-window with the level high through and after reset
        step(8'sd1, 8'sd1, 1'b1, 1'b1);
        step(8'sd1, 8'sd1, 1'b1, 1'b1);
        force_done = 1'b1;
        do_reset();
        valid_count = 0;
        step(8'sd0, 8'sd0, 1'b0, 1'b1);
        step(8'sd0, 8'sd0, 1'b0, 1'b1);
        chk("rst_no_flush", valid_count, 0);
        force_done = 1'b0;
        step(8'sd0, 8'sd0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) step(8'sd1, 8'sd1, 1'b1, 1'b1);
        step(8'sd0, 8'sd0, 1'b0, 1'b1);
        chk("rst_window", out_data_o, 24'sd4);
        for (int k = 0; k < 3; k++) step(8'sd0, 8'sd0, 1'b0, 1'b1);

        // randomized traffic against the window-sum model
        for (int n = 0; n < 3000; n++) begin
            step(8'($urandom), 8'($urandom), ($urandom % 4) != 0, ($urandom % 3) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mac_acc
